// File: rtl/stack_engine_if.sv
// Command, response and memory-bus bundle for stack_engine.
// slave: the engine side. master: the client driving commands and serving memory.
interface stack_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_r;
  logic              mem_w;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, mem_rdata, mem_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           mem_addr, mem_wdata, mem_r, mem_w
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, mem_rdata, mem_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           mem_addr, mem_wdata, mem_r, mem_w
  );
endinterface

// File: rtl/stack_engine.sv
// Stack sequencer: owns the stack pointer, runs PUSH/POP/PEEK/DROP one at a
// time over a ready-handshaked memory bus and reports completion/errors.
// Optional build macro STACK_ENGINE_TIMEOUT_EN adds an ACCESS wait-state bound.
//
// state  | meaning
// IDLE   | ready for a command or an sp_load
// ACCESS | memory request held until mem_ready (or timeout)
// DONE   | one-cycle rsp_valid pulse
module stack_engine #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] SP_INIT        = ADDR_W'(16'h07FF),
  parameter logic [ADDR_W-1:0] SP_LIMIT       = ADDR_W'(16'h0700),
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  stack_engine_if.slave     bus,
  output logic [ADDR_W-1:0] sp,
  input  logic              sp_load,
  input  logic [ADDR_W-1:0] sp_load_val,
  output logic              overflow,
  output logic              underflow,
  output logic              timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_DROP = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_r_q, mem_r_d;
  logic              mem_w_q, mem_w_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

`ifdef STACK_ENGINE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  logic push_ok, pop_ok;
  assign push_ok = (sp_q >= SP_LIMIT);
  assign pop_ok  = (sp_q < SP_INIT);

  // Next-state and datapath decisions for all registers.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sp_d        = sp_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_r_d     = mem_r_q;
    mem_w_d     = mem_w_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
`ifdef STACK_ENGINE_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sp_load) begin
          sp_d = sp_load_val;
        end else if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
`ifdef STACK_ENGINE_TIMEOUT_EN
          cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          case (bus.cmd_op)
            OP_PUSH: begin
              if (push_ok) begin
                state_d     = S_ACCESS;
                mem_addr_d  = sp_q;
                mem_wdata_d = bus.cmd_data;
                mem_w_d     = 1'b1;
              end else begin
                ovf_d       = 1'b1;
                state_d     = S_DONE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
              end
            end
            OP_POP, OP_PEEK: begin
              if (pop_ok) begin
                state_d    = S_ACCESS;
                mem_addr_d = sp_q + ADDR_W'(1);
                mem_r_d    = 1'b1;
              end else begin
                unf_d       = 1'b1;
                state_d     = S_DONE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
              end
            end
            default: begin
              // DROP never touches memory
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
              if (pop_ok) begin
                sp_d      = sp_q + ADDR_W'(1);
                rsp_err_d = 1'b0;
              end else begin
                unf_d     = 1'b1;
                rsp_err_d = 1'b1;
              end
            end
          endcase
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          mem_r_d     = 1'b0;
          mem_w_d     = 1'b0;
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          case (op_q)
            OP_PUSH: sp_d = sp_q - ADDR_W'(1);
            OP_POP: begin
              sp_d       = sp_q + ADDR_W'(1);
              rsp_data_d = bus.mem_rdata;
            end
            default: rsp_data_d = bus.mem_rdata;
          endcase
`ifdef STACK_ENGINE_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          mem_r_d     = 1'b0;
          mem_w_d     = 1'b0;
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          tmo_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
`endif
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        rsp_err_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        mem_r_d = 1'b0;
        mem_w_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PUSH;
      sp_q        <= SP_INIT;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_r_q     <= 1'b0;
      mem_w_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
`ifdef STACK_ENGINE_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sp_q        <= sp_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_r_q     <= mem_r_d;
      mem_w_q     <= mem_w_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
`ifdef STACK_ENGINE_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  // sp_load blocks acceptance combinationally so the load always wins.
  assign bus.cmd_ready = (state_q == S_IDLE) && !sp_load;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_r     = mem_r_q;
  assign bus.mem_w     = mem_w_q;
  assign sp            = sp_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;
`ifdef STACK_ENGINE_TIMEOUT_EN
  assign timeout       = tmo_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: transaction-level model of the stack, memory and
// fault flags, checked against the DUT on every negedge, plus literal pins.
module tb_stack_engine;
  localparam int TO = 4;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, PEEK = 2'b10, DROP = 2'b11;
  localparam logic [15:0] SPI = 16'h07FF, SPL = 16'h0700;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sp;
  logic        sp_load = 1'b0;
  logic [15:0] sp_load_val = '0;
  logic        overflow, underflow, timeout;

  stack_engine_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  stack_engine #(.DATA_W(16), .ADDR_W(16), .SP_INIT(SPI), .SP_LIMIT(SPL),
                 .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .sp(sp),
    .sp_load(sp_load), .sp_load_val(sp_load_val),
    .overflow(overflow), .underflow(underflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // memory slave
  logic [15:0] bus_mem [0:65535];
  assign bus.mem_rdata = bus_mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_w && bus.mem_ready) bus_mem[bus.mem_addr] <= bus.mem_wdata;

  // model state
  logic [15:0] ref_mem [0:65535];
  logic [15:0] exp_sp, exp_addr, exp_wdata, exp_rsp_data;
  logic exp_ready, exp_mem_r, exp_mem_w, exp_rsp_valid, exp_rsp_err;
  logic exp_ovf, exp_unf, exp_tmo;
  logic check_en = 1'b0;
  int tests = 0, fails = 0, mem_req_cycles = 0;
  logic last_valid, last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against model
  always @(negedge clk) begin
    if (check_en && reset_n) begin
      chk("cmd_ready", bus.cmd_ready, exp_ready);
      chk("rsp_valid", bus.rsp_valid, exp_rsp_valid);
      if (exp_rsp_valid) chk("rsp_err", bus.rsp_err, exp_rsp_err);
      chk("rsp_data", bus.rsp_data, exp_rsp_data);
      chk("mem_w", bus.mem_w, exp_mem_w);
      chk("mem_r", bus.mem_r, exp_mem_r);
      if (exp_mem_w || exp_mem_r) chk("mem_addr", bus.mem_addr, exp_addr);
      if (exp_mem_w) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      chk("sp", sp, exp_sp);
      chk("overflow", overflow, exp_ovf);
      chk("underflow", underflow, exp_unf);
      chk("timeout", timeout, exp_tmo);
      if (bus.mem_r || bus.mem_w) mem_req_cycles++;
    end
  end

  task automatic model_reset();
    exp_sp = SPI; exp_ready = 1'b1; exp_mem_r = 1'b0; exp_mem_w = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_rsp_valid = 1'b0; exp_rsp_err = 1'b0;
    exp_rsp_data = '0; exp_ovf = 1'b0; exp_unf = 1'b0; exp_tmo = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; sp_load = 1'b0; bus.mem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // one command, starting 1 time unit after a posedge; waits = mem_ready-low cycles
  task automatic cmd(input logic [1:0] op, input logic [15:0] data, input int waits);
    logic legal;
    int hold;
    logic abort;
    legal = (op == PUSH) ? (exp_sp >= SPL) : (exp_sp < SPI);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    exp_ready = 1'b0;
    if (legal && op != DROP) begin
      hold = waits + 1;
      abort = 1'b0;
`ifdef STACK_ENGINE_TIMEOUT_EN
      if (hold > TO) begin hold = TO; abort = 1'b1; end
`endif
      exp_mem_w = (op == PUSH);
      exp_mem_r = (op != PUSH);
      exp_addr  = (op == PUSH) ? exp_sp : exp_sp + 16'd1;
      if (op == PUSH) exp_wdata = data;
      for (int i = 0; i < hold; i++) begin
        bus.mem_ready = !abort && (i == hold - 1);
        @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      exp_mem_w = 1'b0; exp_mem_r = 1'b0;
      if (abort) begin
        exp_tmo = 1'b1; exp_rsp_err = 1'b1;
      end else begin
        exp_rsp_err = 1'b0;
        case (op)
          PUSH: begin ref_mem[exp_sp] = data; exp_sp = exp_sp - 16'd1; end
          POP:  begin exp_rsp_data = ref_mem[exp_sp + 16'd1]; exp_sp = exp_sp + 16'd1; end
          default: exp_rsp_data = ref_mem[exp_sp + 16'd1];
        endcase
      end
    end else if (legal) begin
      exp_sp = exp_sp + 16'd1; exp_rsp_err = 1'b0;
    end else begin
      exp_rsp_err = 1'b1;
      if (op == PUSH) exp_ovf = 1'b1; else exp_unf = 1'b1;
    end
    exp_rsp_valid = 1'b1;
    #2;
    last_valid = bus.rsp_valid; last_err = bus.rsp_err;
    @(posedge clk); #1;
    exp_rsp_valid = 1'b0; exp_ready = 1'b1;
  endtask

  task automatic load(input logic [15:0] val, input logic with_cmd);
    sp_load = 1'b1; sp_load_val = val;
    bus.cmd_valid = with_cmd; bus.cmd_op = PUSH; bus.cmd_data = 16'hDEAD;
    exp_ready = 1'b0;
    @(posedge clk); #1;
    sp_load = 1'b0; bus.cmd_valid = 1'b0;
    exp_sp = val; exp_ready = 1'b1;
  endtask

  int base;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = PUSH; bus.cmd_data = '0; bus.mem_ready = 1'b0;
    do_reset();
    check_en = 1'b1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_sp", sp, 16'h07FF);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_mem_rw", {bus.mem_r, bus.mem_w}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_flags", {overflow, underflow, timeout}, 0);

    base = mem_req_cycles;
    cmd(PUSH, 16'hBEEF, 0);
    chk("lit_push_valid", last_valid, 1);
    chk("lit_push_err", last_err, 0);
    chk("lit_push_sp", sp, 16'h07FE);
    chk("lit_push_req_cycles", mem_req_cycles - base, 1);
    chk("lit_push_mem", bus_mem[16'h07FF], 16'hBEEF);

    cmd(POP, 16'h0, 0);
    chk("lit_pop_data", bus.rsp_data, 16'hBEEF);
    chk("lit_pop_sp", sp, 16'h07FF);
    base = mem_req_cycles;
    cmd(POP, 16'h0, 0);
    chk("lit_underflow_err", last_err, 1);
    chk("lit_underflow_flag", underflow, 1);
    chk("lit_underflow_noreq", mem_req_cycles - base, 0);

    cmd(PUSH, 16'h1234, 0);
    cmd(PEEK, 16'h0, 0);
    chk("lit_peek_data", bus.rsp_data, 16'h1234);
    chk("lit_peek_sp", sp, 16'h07FE);
    base = mem_req_cycles;
    cmd(DROP, 16'h0, 0);
    chk("lit_drop_sp", sp, 16'h07FF);
    chk("lit_drop_noreq", mem_req_cycles - base, 0);
    cmd(DROP, 16'h0, 0);
    chk("lit_drop_empty_err", last_err, 1);

    load(16'h06FF, 1'b1);
    chk("lit_load_sp", sp, 16'h06FF);
    cmd(PUSH, 16'h7777, 0);
    chk("lit_overflow_err", last_err, 1);
    chk("lit_overflow_flag", overflow, 1);
    chk("lit_overflow_sp", sp, 16'h06FF);

    load(16'h0700, 1'b0);
    cmd(PUSH, 16'h0A0A, 1);
    chk("lit_limit_push_err", last_err, 0);
    chk("lit_limit_push_sp", sp, 16'h06FF);
    cmd(POP, 16'h0, 0);
    chk("lit_limit_pop_data", bus.rsp_data, 16'h0A0A);

    load(16'h07FF, 1'b0);
    base = mem_req_cycles;
    cmd(PUSH, 16'h5A5A, 3);
    chk("lit_wait_req_cycles", mem_req_cycles - base, 4);
    cmd(PUSH, 16'hC001, 2);
    cmd(PUSH, 16'hC002, 0);
    cmd(PEEK, 16'h0, 1);
    cmd(POP, 16'h0, 0);
    cmd(POP, 16'h0, 2);
    cmd(POP, 16'h0, 1);
    chk("lit_lifo_last", bus.rsp_data, 16'h5A5A);
    chk("lit_lifo_sp", sp, 16'h07FF);

`ifdef STACK_ENGINE_TIMEOUT_EN
    cmd(PUSH, 16'h4444, 100);
    chk("lit_timeout_err", last_err, 1);
    chk("lit_timeout_flag", timeout, 1);
    chk("lit_timeout_sp", sp, 16'h07FF);
`endif

    // reset during ACCESS
    cmd(PUSH, 16'h1111, 0);
    bus.cmd_valid = 1'b1; bus.cmd_op = PUSH; bus.cmd_data = 16'hA5A5;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.mem_ready = 1'b0;
    exp_ready = 1'b0; exp_mem_w = 1'b1; exp_addr = exp_sp; exp_wdata = 16'hA5A5;
    @(posedge clk); #3;
    chk("lit_mid_access_mem_w", bus.mem_w, 1);
    reset_n = 1'b0;
    #1;
    chk("lit_async_mem_w_drop", bus.mem_w, 0);
    chk("lit_async_sp", sp, 16'h07FF);
    do_reset();
    chk("lit_after_rst_ready", bus.cmd_ready, 1);
    chk("lit_after_rst_flags", {overflow, underflow, timeout}, 0);
    repeat (3) @(posedge clk);
    #1;
    cmd(POP, 16'h0, 0);
    chk("lit_after_rst_pop_err", last_err, 1);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
